morse_digit_tx: RTL and testbench

//  Sequential successor to the combinational digit-to-Morse LED decoder.

---
 rtl/morse_pkg.sv | 29 ++
 rtl/morse_fifo.sv | 52 +++++
 rtl/morse_digit_tx.sv | 139 +++++++++++++
 tb/tb_morse_digit_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse digit transmitter.
package morse_pkg;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_e;

  localparam int DOT_UNITS   = 1;
  localparam int DASH_UNITS  = 3;
  localparam int SPACE_UNITS = 1;
  localparam int GAP_UNITS   = 3;
  localparam int ELEMS       = 5;

  // Element order is m1 (MSB) first; 1 = dot, 0 = dash.
  function automatic logic [ELEMS-1:0] digit_to_pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 5'b00000;
      4'd1:    return 5'b10000;
      4'd2:    return 5'b11000;
      4'd3:    return 5'b11100;
      4'd4:    return 5'b11110;
      4'd5:    return 5'b11111;
      4'd6:    return 5'b01111;
      4'd7:    return 5'b00111;
      4'd8:    return 5'b00011;
      4'd9:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/morse_fifo.sv
// Small show-ahead FIFO for queued digits; full/empty derive from an occupancy count.
module morse_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/morse_digit_tx.sv
// Queues BCD digits and keys each one out as timed Morse on a single lamp.
module morse_digit_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       ready,
  output logic       led,
  output logic [4:0] pattern,
  output logic       red,
  output logic       busy,
  output logic       full,
  output logic       drop
);

  localparam int          CW     = $clog2(3*UNIT_CYCLES+1);
  localparam logic [2:0]  LAST_E = 3'(ELEMS-1);

  function automatic logic [CW-1:0] load(input int units);
    return CW'(units*UNIT_CYCLES - 1);
  endfunction

  function automatic logic [CW-1:0] mark_load(input logic dot);
    return dot ? load(DOT_UNITS) : load(DASH_UNITS);
  endfunction

  state_e       state_q, state_d;
  logic [2:0]   e_q, e_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]   pattern_q, pattern_d;
  logic         led_q, led_d, red_q, red_d, drop_q, drop_d, busy_q, busy_d;
  logic         digit_ok, push, pop, fifo_full, fifo_empty;
  logic [3:0]   fifo_dout;

  assign digit_ok = (digit <= 4'd9);
  assign push     = ready && digit_ok && !fifo_full;

  morse_fifo #(.W(4), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (digit),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    pop       = 1'b0;
    red_d     = red_q;
    drop_d    = 1'b0;

    if (ready) begin
      if (!digit_ok)       red_d  = 1'b1;
      else if (!fifo_full) red_d  = 1'b0;
      else                 drop_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          pattern_d = digit_to_pattern(fifo_dout);
          e_d       = '0;
          cnt_d     = mark_load(pattern_d[LAST_E]);
          state_d   = MARK;
        end
      end
      MARK: begin
        if (cnt_q == '0) begin
          if (e_q == LAST_E) begin
            cnt_d   = load(GAP_UNITS);
            state_d = GAP;
          end else begin
            cnt_d   = load(SPACE_UNITS);
            state_d = SPACE;
          end
        end else cnt_d = cnt_q - CW'(1);
      end
      SPACE: begin
        if (cnt_q == '0) begin
          e_d     = e_q + 3'd1;
          cnt_d   = mark_load(pattern_q[LAST_E - e_d]);
          state_d = MARK;
        end else cnt_d = cnt_q - CW'(1);
      end
      GAP: begin
        if (cnt_q == '0) begin
          pattern_d = '0;
          state_d   = IDLE;
        end else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Lamp tracks the next state so it rises on the same edge as the pop.
    led_d  = (state_d == MARK);
    busy_d = push || !fifo_empty || (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      e_q       <= '0;
      cnt_q     <= '0;
      pattern_q <= '0;
      led_q     <= 1'b0;
      red_q     <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      led_q     <= led_d;
      red_q     <= red_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  assign led     = led_q;
  assign pattern = pattern_q;
  assign red     = red_q;
  assign busy    = busy_q;
  assign full    = fifo_full;
  assign drop    = drop_q;

endmodule

// File: tb/tb_morse_digit_tx.sv
// Directed bench for morse_digit_tx at UNIT_CYCLES=2, FIFO_DEPTH=4.
module tb_morse_digit_tx;

  logic       clk = 1'b0;
  logic       reset, ready;
  logic [3:0] digit;
  logic       led, red, busy, full, drop;
  logic [4:0] pattern;

  int errors = 0;
  int checks = 0;

  logic       led_tr  [256];
  logic [4:0] pat_tr  [256];
  logic       busy_tr [256];
  logic       exp_tr  [256];
  int         exp_len;

  morse_digit_tx #(.UNIT_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .digit(digit), .ready(ready), .led(led),
    .pattern(pattern), .red(red), .busy(busy), .full(full), .drop(drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    ready = 1'b1;
    digit = d;
    step();
    ready = 1'b0;
  endtask

  // Sample index k = value just after the k-th edge following the last push.
  task automatic run_cycles(input int n, input int push_at, input logic [3:0] pd);
    for (int k = 0; k < n; k++) begin
      led_tr[k]  = led;
      pat_tr[k]  = pattern;
      busy_tr[k] = busy;
      if (k == push_at) begin
        ready = 1'b1;
        digit = pd;
      end else ready = 1'b0;
      step();
    end
    ready = 1'b0;
  endtask

  task automatic exp_clear();
    for (int k = 0; k < 256; k++) exp_tr[k] = 1'b0;
    exp_len = 0;
  endtask

  task automatic exp_add(input logic v, input int len);
    for (int i = 0; i < len; i++) begin
      exp_tr[exp_len] = v;
      exp_len = exp_len + 1;
    end
  endtask

  function automatic int first_diff(input int n);
    for (int k = 0; k < n; k++)
      if (led_tr[k] !== exp_tr[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b0; ready = 1'b0; digit = 4'd0;
    step(); step();
    checks++; if (led !== 1'b0)      begin errors++; $display("FAIL reset_led: got %b want 0", led); end
    checks++; if (pattern !== 5'b0)  begin errors++; $display("FAIL reset_pattern: got %b want 00000", pattern); end
    checks++; if (red !== 1'b0)      begin errors++; $display("FAIL reset_red: got %b want 0", red); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (drop !== 1'b0)     begin errors++; $display("FAIL reset_drop: got %b want 0", drop); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_digit5();
    int fd;
    bit bad;
    exp_clear();
    exp_add(1'b0, 1);
    for (int j = 0; j < 5; j++) begin
      exp_add(1'b1, 2);
      exp_add(1'b0, (j == 4) ? 7 : 2);
    end
    push(4'd5);
    run_cycles(30, -1, 4'd0);
    fd = first_diff(30);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL digit5_led: cycle %0d got %b want %b", fd, led_tr[fd], exp_tr[fd]);
    end
    bad = (pat_tr[0] !== 5'b0) || (pat_tr[25] !== 5'b0);
    for (int k = 1; k <= 24; k++) if (pat_tr[k] !== 5'b11111) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL digit5_pattern: k1=%b k24=%b k25=%b want 11111,11111,00000", pat_tr[1], pat_tr[24], pat_tr[25]);
    end
    checks++;
    if (busy_tr[25] !== 1'b1 || busy_tr[26] !== 1'b0) begin
      errors++;
      $display("FAIL digit5_busy_fall: k25=%b k26=%b want 1,0", busy_tr[25], busy_tr[26]);
    end
  endtask

  task automatic test_digit0();
    int fd;
    bit bad;
    exp_clear();
    exp_add(1'b0, 1);
    for (int j = 0; j < 4; j++) begin
      exp_add(1'b1, 6);
      exp_add(1'b0, 2);
    end
    exp_add(1'b1, 6);
    exp_add(1'b0, 7);
    push(4'd0);
    run_cycles(48, -1, 4'd0);
    fd = first_diff(48);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL digit0_led: cycle %0d got %b want %b", fd, led_tr[fd], exp_tr[fd]);
    end
    bad = 1'b0;
    for (int k = 0; k < 48; k++) if (pat_tr[k] !== 5'b0) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL digit0_pattern: got nonzero pattern, want 00000"); end
    checks++;
    if (busy_tr[45] !== 1'b1 || busy_tr[46] !== 1'b0) begin
      errors++;
      $display("FAIL digit0_busy_fall: k45=%b k46=%b want 1,0", busy_tr[45], busy_tr[46]);
    end
  endtask

  task automatic test_invalid_then_3();
    int fd;
    bit bad;
    push(4'd12);
    checks++; if (red !== 1'b1) begin errors++; $display("FAIL invalid_red_set: got %b want 1", red); end
    run_cycles(4, -1, 4'd0);
    bad = 1'b0;
    for (int k = 0; k < 4; k++) if (led_tr[k] !== 1'b0 || busy_tr[k] !== 1'b0) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL invalid_quiet: led/busy got activity, want 0"); end
    exp_clear();
    exp_add(1'b0, 1);
    for (int j = 0; j < 3; j++) begin exp_add(1'b1, 2); exp_add(1'b0, 2); end
    exp_add(1'b1, 6); exp_add(1'b0, 2);
    exp_add(1'b1, 6); exp_add(1'b0, 7);
    push(4'd3);
    checks++; if (red !== 1'b0) begin errors++; $display("FAIL invalid_red_clear: got %b want 0", red); end
    run_cycles(36, -1, 4'd0);
    fd = first_diff(36);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL digit3_led: cycle %0d got %b want %b", fd, led_tr[fd], exp_tr[fd]);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] seen[$];
    logic [4:0] want [5];
    logic [4:0] prev;
    bit done, bad;
    want = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};
    for (int d = 1; d <= 6; d++) begin
      ready = 1'b1;
      digit = 4'(d);
      step();
      if (d == 5) begin
        checks++;
        if (full !== 1'b1 || drop !== 1'b0) begin
          errors++; $display("FAIL b2b_full_after5: full=%b drop=%b want 1,0", full, drop);
        end
      end
      if (d == 6) begin
        checks++;
        if (drop !== 1'b1 || full !== 1'b1) begin
          errors++; $display("FAIL b2b_drop_on6: drop=%b full=%b want 1,1", drop, full);
        end
      end
    end
    ready = 1'b0;
    step();
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL b2b_drop_pulse: got %b want 0", drop); end
    prev = 5'b0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (pattern !== 5'b0 && pattern !== prev) seen.push_back(pattern);
      prev = pattern;
      if (busy === 1'b0) done = 1'b1;
      else step();
    end
    checks++; if (!done) begin errors++; $display("FAIL b2b_timeout: busy still %b after 400 cycles, want 0", busy); end
    bad = (seen.size() != 5);
    if (!bad) for (int i = 0; i < 5; i++) if (seen[i] !== want[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_order: saw %0d patterns, first %b, want 5 starting 10000", seen.size(),
               (seen.size() > 0) ? seen[0] : 5'b0);
    end
  endtask

  task automatic test_reset_mid();
    int fd;
    bit bad;
    push(4'd7);
    for (int i = 0; i < 4; i++) push(4'd8);
    push(4'd15);
    checks++;
    if (led !== 1'b1 || full !== 1'b1 || red !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: led=%b full=%b red=%b want 1,1,1", led, full, red);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({led, pattern, busy, full, red, drop} !== 10'b0) begin
      errors++;
      $display("FAIL rstmid_clear: led=%b pat=%b busy=%b full=%b red=%b drop=%b want all 0",
               led, pattern, busy, full, red, drop);
    end
    run_cycles(5, -1, 4'd0);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) if (led_tr[k] !== 1'b0 || busy_tr[k] !== 1'b0) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL rstmid_fifo_empty: activity after reset, want none"); end
    exp_clear();
    exp_add(1'b0, 1);
    for (int j = 0; j < 3; j++) begin exp_add(1'b1, 6); exp_add(1'b0, 2); end
    exp_add(1'b1, 2); exp_add(1'b0, 2);
    exp_add(1'b1, 2); exp_add(1'b0, 7);
    push(4'd8);
    run_cycles(42, -1, 4'd0);
    fd = first_diff(42);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL digit8_led: cycle %0d got %b want %b", fd, led_tr[fd], exp_tr[fd]);
    end
  endtask

  task automatic test_gap_push();
    int fd;
    exp_clear();
    exp_add(1'b0, 1);
    for (int j = 0; j < 4; j++) begin exp_add(1'b1, 2); exp_add(1'b0, 2); end
    exp_add(1'b1, 2); exp_add(1'b0, 7);
    exp_add(1'b1, 6); exp_add(1'b0, 2); exp_add(1'b1, 6);
    push(4'd5);
    run_cycles(40, 20, 4'd9);
    fd = first_diff(40);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL gap_led: cycle %0d got %b want %b", fd, led_tr[fd], exp_tr[fd]);
    end
    checks++;
    if (pat_tr[24] !== 5'b11111 || pat_tr[25] !== 5'b0 || pat_tr[26] !== 5'b00001) begin
      errors++;
      $display("FAIL gap_pattern: k24=%b k25=%b k26=%b want 11111,00000,00001", pat_tr[24], pat_tr[25], pat_tr[26]);
    end
    checks++;
    if (busy_tr[25] !== 1'b1 || busy_tr[26] !== 1'b1) begin
      errors++;
      $display("FAIL gap_busy: k25=%b k26=%b want 1,1", busy_tr[25], busy_tr[26]);
    end
  endtask

  initial begin
    test_reset();
    test_digit5();
    test_digit0();
    test_invalid_then_3();
    test_back_to_back();
    test_reset_mid();
    test_gap_push();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
